rr_arbiter_16: RTL and testbench

Round-robin arbiter that shares the 16:1 inverted-index select mux (select 0 -> a[15]) between 16 requesters.
- Owns the mux select: grant_sel drives the mux select directly, so the mux output is the granted requester's data bit.
- Request and grant vectors use the mux ordering: slot k <-> vector bit 15-k.
- Grants are held until release, with an optional forced rotation after a hold limit.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick_16.sv | 33 +++
 rtl/rr_arbiter_16.sv | 101 ++++++++++
 tb/tb_rr_arbiter_16.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 16-slot round-robin arbiter around the inverted-index mux.
// Slot k maps to vector bit 15-k in every request/grant vector.
package arb_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [SEL_W-1:0] slot_bit(input logic [SEL_W-1:0] slot);
        return SEL_W'(N_REQ - 1) - slot;
    endfunction

endpackage

// File: rtl/rr_pick_16.sv
// Combinational round-robin picker: first requesting slot at or after start, wrapping 15->0.
// Works in slot order: rotate so start lands at index 0, priority-encode, then un-rotate.
module rr_pick_16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] winner
);

    logic [N_REQ-1:0] slots;
    logic [N_REQ-1:0] rotated;
    logic [SEL_W-1:0] offset;

    always_comb begin
        slots = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            slots[k] = req[slot_bit(SEL_W'(k))];
        end
        rotated = N_REQ'({slots, slots} >> start);
        found   = 1'b0;
        offset  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rotated[i]) begin
                found  = 1'b1;
                offset = SEL_W'(i);
            end
        end
        winner = start + offset;
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter owning the select of the 16:1 inverted-index mux; grants held until release.
// Optional grant counter port enabled by defining ARB_GRANT_CNT_EN.
module rr_arbiter_16
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_sel,
    output logic [N_REQ-1:0] grant_onehot
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt
`endif
);

    localparam int unsigned HOLD_W = 16;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    logic [SEL_W-1:0]  last_sel;
    logic [HOLD_W-1:0] hold_cnt;
    logic              found;
    logic [SEL_W-1:0]  winner;
    logic [N_REQ-1:0]  win_onehot;
    logic              release_grant;

    rr_pick_16 u_pick (
        .req    (req),
        .start  (last_sel + SEL_W'(1)),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        win_onehot = '0;
        win_onehot[slot_bit(winner)] = 1'b1;
    end

    // Forced rotation only when someone other than the owner is waiting.
    assign release_grant = done
                        || !req[slot_bit(grant_sel)]
                        || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)
                            && |(req & ~grant_onehot));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant_valid  <= 1'b0;
            grant_sel    <= '0;
            grant_onehot <= '0;
            last_sel     <= SEL_W'(N_REQ - 1);
            hold_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && found) begin
                        state        <= GRANT;
                        grant_valid  <= 1'b1;
                        grant_sel    <= winner;
                        grant_onehot <= win_onehot;
                        last_sel     <= winner;
                        hold_cnt     <= '0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    if (release_grant) begin
                        state        <= IDLE;
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
        end else if (state == IDLE && en && found && grant_cnt != '1) begin
            grant_cnt <= grant_cnt + CNT_W'(1);
        end
    end
`else
    if (CNT_W == 0) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus randomized traffic
// checked against a slot-level behavioural model. Honours ARB_GRANT_CNT_EN.
module tb_rr_arbiter_16;

    localparam int MH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic        grant_valid;
    logic [3:0]  grant_sel;
    logic [15:0] grant_onehot;
`ifdef ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state, in slot terms
    bit m_valid = 0;
    int m_sel   = 0;
    int m_last  = 15;
    int m_hold  = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    rr_arbiter_16 #(.MAX_HOLD(MH), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .req          (req),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_sel    (grant_sel),
        .grant_onehot (grant_onehot)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    function automatic bit slot_req(input logic [15:0] r, input int slot);
        return r[15 - slot];
    endfunction

    // Advance one clock; the model consumes the inputs as they stand before the edge.
    task automatic tick();
        bit nv = m_valid;
        int ns = m_sel, nl = m_last, nh = m_hold, nc = m_cnt;
        bit others = 0;
        bit rel;
        if (reset) begin
            nv = 0; ns = 0; nl = 15; nh = 0; nc = 0;
        end else if (!m_valid) begin
            if (en && req != 0) begin
                for (int i = 1; i <= 16; i++) begin
                    int s = (m_last + i) % 16;
                    if (!nv && slot_req(req, s)) begin
                        nv = 1; ns = s; nl = s;
                    end
                end
                nh = 0;
                if (nc < 65535) nc = nc + 1;
            end
        end else begin
            for (int s = 0; s < 16; s++)
                if (s != m_sel && slot_req(req, s)) others = 1;
            rel = done || !slot_req(req, m_sel) || (MH != 0 && m_hold == MH - 1 && others);
            nh = (m_hold + 1 > MH) ? MH : m_hold + 1;
            if (rel) nv = 0;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_sel = ns; m_last = nl; m_hold = nh; m_cnt = nc;
    endtask

    task automatic do_reset();
        reset = 1'b1; done = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant_valid !== 1'b0 || grant_sel !== 4'd0 || grant_onehot !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b sel=%0d onehot=%h, want 0/0/0000",
                     grant_valid, grant_sel, grant_onehot);
        end
`ifdef ARB_GRANT_CNT_EN
        checks++;
        if (grant_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", grant_cnt);
        end
`endif
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1; req = 16'h8000;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_sel !== 4'd0 || grant_onehot !== 16'h8000) begin
            errors++;
            $display("FAIL single_grant: valid=%b sel=%0d onehot=%h, want 1/0/8000",
                     grant_valid, grant_sel, grant_onehot);
        end
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || grant_onehot !== 16'h0) begin
            errors++;
            $display("FAIL single_release: valid=%b onehot=%h, want 0/0000", grant_valid, grant_onehot);
        end
        // Sole requester is re-granted after the bubble
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_sel !== 4'd0) begin
            errors++;
            $display("FAIL sole_regrant: valid=%b sel=%0d, want 1/0", grant_valid, grant_sel);
        end
        req = '0; tick(); tick();
    endtask

    task automatic test_rotation();
        do_reset();
        en = 1'b1; req = 16'hFFFF;
        tick();
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_sel !== 4'(k % 16)
                || grant_onehot !== (16'h8000 >> (k % 16))) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: valid=%b sel=%0d onehot=%h, want sel %0d",
                         k, grant_valid, grant_sel, grant_onehot, k % 16);
            end
            done = 1'b1; tick(); done = 1'b0;
            checks++;
            if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL rotation_bubble[%0d]: valid=%b want 0", k, grant_valid);
            end
            tick();
        end
        req = '0; tick(); tick();
    endtask

    task automatic test_forced();
        do_reset();
        en = 1'b1; req = 16'hC000;
        tick();
        for (int t = 0; t < 27; t++) begin
            int p = t % 9;
            int owner = (t / 9) % 2;
            checks++;
            if (p < 8) begin
                if (grant_valid !== 1'b1 || grant_sel !== 4'(owner)) begin
                    errors++;
                    $display("FAIL forced_hold[t=%0d]: valid=%b sel=%0d, want 1/%0d",
                             t, grant_valid, grant_sel, owner);
                end
            end else if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL forced_bubble[t=%0d]: valid=%b want 0", t, grant_valid);
            end
            tick();
        end
        req = '0; tick(); tick();
    endtask

    task automatic test_hold_alone();
        do_reset();
        en = 1'b1; req = 16'h0001;
        tick();
        for (int t = 0; t < 50; t++) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_sel !== 4'd15 || grant_onehot !== 16'h0001) begin
                errors++;
                $display("FAIL hold_alone[t=%0d]: valid=%b sel=%0d onehot=%h, want 1/15/0001",
                         t, grant_valid, grant_sel, grant_onehot);
            end
            tick();
        end
        req = '0; tick(); tick();
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; req = 16'h0F00;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_low_idle[t=%0d]: valid=%b want 0", t, grant_valid);
            end
        end
        en = 1'b1; tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_sel !== 4'd4 || grant_onehot !== 16'h0800) begin
            errors++;
            $display("FAIL en_rise_grant: valid=%b sel=%0d onehot=%h, want 1/4/0800",
                     grant_valid, grant_sel, grant_onehot);
        end
        en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_sel !== 4'd4) begin
                errors++;
                $display("FAIL en_drop_hold[t=%0d]: valid=%b sel=%0d, want 1/4", t, grant_valid, grant_sel);
            end
        end
        done = 1'b1; tick(); done = 1'b0;
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_drop_nogrant[t=%0d]: valid=%b want 0", t, grant_valid);
            end
            tick();
        end
        req = '0; en = 1'b1; tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        en = 1'b1; req = 16'h0040;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_sel !== 4'd9) begin
            errors++;
            $display("FAIL mid_pre_grant: valid=%b sel=%0d, want 1/9", grant_valid, grant_sel);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || grant_onehot !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b onehot=%h, want 0/0000", grant_valid, grant_onehot);
        end
`ifdef ARB_GRANT_CNT_EN
        checks++;
        if (grant_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_cnt: got %0d want 0", grant_cnt);
        end
`endif
        req = 16'h0041; tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_sel !== 4'd9) begin
            errors++;
            $display("FAIL mid_first_winner: valid=%b sel=%0d, want 1/9", grant_valid, grant_sel);
        end
        done = 1'b1; tick(); done = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_sel !== 4'd15) begin
            errors++;
            $display("FAIL mid_second_winner: valid=%b sel=%0d, want 1/15", grant_valid, grant_sel);
        end
        req = '0; tick(); tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            logic [15:0] r = 16'($urandom());
            if ($urandom_range(0, 2) == 0) r = r & 16'($urandom());
            if ($urandom_range(0, 9) == 0) r = '0;
            req   = r;
            en    = ($urandom_range(0, 7) != 0);
            done  = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (grant_valid !== m_valid || grant_sel !== 4'(m_sel)
                || grant_onehot !== (m_valid ? (16'h8000 >> m_sel) : 16'h0)) begin
                errors++;
                $display("FAIL random[t=%0d]: valid=%b sel=%0d onehot=%h, want %b/%0d/%h",
                         t, grant_valid, grant_sel, grant_onehot, m_valid, m_sel,
                         m_valid ? (16'h8000 >> m_sel) : 16'h0);
            end
`ifdef ARB_GRANT_CNT_EN
            checks++;
            if (grant_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random_cnt[t=%0d]: got %0d want %0d", t, grant_cnt, m_cnt);
            end
`endif
        end
        reset = 1'b0; done = 1'b0; req = '0; en = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_forced();
        test_hold_alone();
        test_enable();
        test_reset_mid_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
